hazard_detect_unit: RTL and testbench

//   ID-stage hazard detector and pipeline stall/flush controller, directly upstream of

---
 rtl/hazard_detect_unit.sv | 86 ++++++++
 tb/tb_hazard_detect_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard detector: load-use and mult/div-busy stalls, branch/jump flushes,
// and the registered load-use bubble tag consumed by the forwarding unit.
module hazard_detect_unit #(
    parameter int unsigned MD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       use_rs_id,
    input  logic       use_rt_id,
    input  logic       md_use_id,
    input  logic       jump_id,
    input  logic [4:0] rw_ex,
    input  logic       regWr_ex,
    input  logic       memRd_ex,
    input  logic       md_start_ex,
    input  logic       branch_taken_ex,
    output logic       pcWr,
    output logic       ifidWr,
    output logic       ifidFlush,
    output logic       idexFlush,
    output logic [1:0] bubble,
    output logic       md_busy
);

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES);

    logic [3:0] md_cnt_q, md_cnt_d;
    logic [1:0] bubble_q, bubble_d;
    logic       lu_hit;
    logic       md_hit;

    assign lu_hit = memRd_ex & regWr_ex & (rw_ex != 5'd0) &
                    ((use_rs_id & (rs_id == rw_ex)) | (use_rt_id & (rt_id == rw_ex)));
    assign md_busy = (md_cnt_q != 4'd0);
    assign md_hit  = md_busy & md_use_id;
    assign bubble  = bubble_q;

    // A flush does not touch the counter: the issued mult/div is architectural.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_ex) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
        bubble_d = (lu_hit & ~branch_taken_ex) ? 2'b01 : 2'b00;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q <= 4'd0;
            bubble_q <= 2'b00;
        end else begin
            md_cnt_q <= md_cnt_d;
            bubble_q <= bubble_d;
        end
    end

    // Stall/flush control is zero-latency; branch flush outranks every stall source.
    always_comb begin
        // NOTE: defaults first so no path through the priority chain leaves an output unassigned (no latch).
        pcWr      = 1'b1;
        ifidWr    = 1'b1;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        if (rst) begin
            pcWr      = 1'b0;
            ifidWr    = 1'b0;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (branch_taken_ex) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (lu_hit || md_hit) begin
            pcWr      = 1'b0;
            ifidWr    = 1'b0;
            idexFlush = 1'b1;
        end else if (jump_id) begin
            ifidFlush = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit: directed spec scenarios, then random
// stimulus against a cycle-level reference model of the stall/flush rules.
module tb_hazard_detect_unit;

    localparam int unsigned MD = 4;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rw;
        logic       use_rs;
        logic       use_rt;
        logic       md_use;
        logic       jump;
        logic       regwr;
        logic       memrd;
        logic       md_start;
        logic       br;
    } in_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    in_t        cur = '0;
    logic       pcWr, ifidWr, ifidFlush, idexFlush, md_busy;
    logic [1:0] bubble;

    int tests = 0;
    int fails = 0;

    // Reference model: remaining mult/div cycles and whether the last cycle was a kept load-use stall.
    int   m_rem = 0;
    logic m_bub = 1'b0;

    always #5 clk = ~clk;

    hazard_detect_unit #(.MD_CYCLES(MD)) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_id           (cur.rs),
        .rt_id           (cur.rt),
        .use_rs_id       (cur.use_rs),
        .use_rt_id       (cur.use_rt),
        .md_use_id       (cur.md_use),
        .jump_id         (cur.jump),
        .rw_ex           (cur.rw),
        .regWr_ex        (cur.regwr),
        .memRd_ex        (cur.memrd),
        .md_start_ex     (cur.md_start),
        .branch_taken_ex (cur.br),
        .pcWr            (pcWr),
        .ifidWr          (ifidWr),
        .ifidFlush       (ifidFlush),
        .idexFlush       (idexFlush),
        .bubble          (bubble),
        .md_busy         (md_busy)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_lu(input in_t s);
        return s.memrd && s.regwr && (s.rw != 5'd0) &&
               ((s.use_rs && s.rs == s.rw) || (s.use_rt && s.rt == s.rw));
    endfunction

    task automatic check_model(input string tag);
        logic [3:0] e;  // {pcWr, ifidWr, ifidFlush, idexFlush}
        if (rst)                           e = 4'b0011;
        else if (cur.br)                   e = 4'b1111;
        else if (model_lu(cur))            e = 4'b0001;
        else if (m_rem > 0 && cur.md_use)  e = 4'b0001;
        else if (cur.jump)                 e = 4'b1110;
        else                               e = 4'b1100;
        check({tag, ".ctl"}, {pcWr, ifidWr, ifidFlush, idexFlush}, e);
        check({tag, ".bubble"}, {2'b00, bubble}, {2'b00, 1'b0, m_bub});
        check({tag, ".md_busy"}, {3'b000, md_busy}, {3'b000, (m_rem > 0)});
    endtask

    task automatic expect_now(input string tag, input logic [3:0] ctl, input logic [1:0] bub, input logic busy);
        check({tag, ".ctl_k"}, {pcWr, ifidWr, ifidFlush, idexFlush}, ctl);
        check({tag, ".bubble_k"}, {2'b00, bubble}, {2'b00, bub});
        check({tag, ".busy_k"}, {3'b000, md_busy}, {3'b000, busy});
    endtask

    // Drive at the falling edge, sample 1 ns later, well away from the rising edge.
    task automatic step_begin(input in_t s, input string tag);
        cur = s;
        #1;
        check_model(tag);
    endtask

    task automatic step_end();
        if (!rst) begin
            m_bub = model_lu(cur) && !cur.br;
            if (cur.md_start)   m_rem = MD;
            else if (m_rem > 0) m_rem = m_rem - 1;
        end
        @(negedge clk);
    endtask

    initial begin
        in_t s;

        // Reset state
        @(negedge clk);
        #1;
        expect_now("reset", 4'b0011, 2'b00, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: load-use on rs -> one stall, bubble tag next cycle, then clear
        s = '0; s.rw = 5'd9; s.memrd = 1; s.regwr = 1; s.rs = 5'd9; s.use_rs = 1;
        step_begin(s, "t1a"); expect_now("t1a", 4'b0001, 2'b00, 1'b0); step_end();
        s = '0;
        step_begin(s, "t1b"); expect_now("t1b", 4'b1100, 2'b01, 1'b0); step_end();
        step_begin(s, "t1c"); expect_now("t1c", 4'b1100, 2'b00, 1'b0); step_end();

        // 1b: load-use via rt
        s = '0; s.rw = 5'd17; s.memrd = 1; s.regwr = 1; s.rt = 5'd17; s.use_rt = 1;
        step_begin(s, "t1rt"); expect_now("t1rt", 4'b0001, 2'b00, 1'b0); step_end();
        s = '0;
        step_begin(s, "t1rt_n"); step_end();

        // 2: rw_ex = 0 never hazards
        s = '0; s.rw = 5'd0; s.memrd = 1; s.regwr = 1; s.rs = 5'd0; s.use_rs = 1;
        step_begin(s, "t2a"); expect_now("t2a", 4'b1100, 2'b00, 1'b0); step_end();
        s = '0;
        step_begin(s, "t2b"); expect_now("t2b", 4'b1100, 2'b00, 1'b0); step_end();

        // 3: branch overrides load-use; no bubble tag
        s = '0; s.rw = 5'd9; s.memrd = 1; s.regwr = 1; s.rs = 5'd9; s.use_rs = 1; s.br = 1;
        step_begin(s, "t3a"); expect_now("t3a", 4'b1111, 2'b00, 1'b0); step_end();
        s = '0;
        step_begin(s, "t3b"); expect_now("t3b", 4'b1100, 2'b00, 1'b0); step_end();

        // 4: mult/div busy for MD cycles with consumer waiting
        s = '0; s.md_start = 1;
        step_begin(s, "t4s"); step_end();
        s = '0; s.md_use = 1;
        for (int i = 0; i < 4; i++) begin
            step_begin(s, "t4busy"); expect_now("t4busy", 4'b0001, 2'b00, 1'b1); step_end();
        end
        step_begin(s, "t4done"); expect_now("t4done", 4'b1100, 2'b00, 1'b0); step_end();

        // 5: jump alone flushes IF/ID; with load-use the stall wins
        s = '0; s.jump = 1;
        step_begin(s, "t5a"); expect_now("t5a", 4'b1110, 2'b00, 1'b0); step_end();
        s.rw = 5'd3; s.memrd = 1; s.regwr = 1; s.rt = 5'd3; s.use_rt = 1;
        step_begin(s, "t5b"); expect_now("t5b", 4'b0001, 2'b00, 1'b0); step_end();
        s = '0;
        step_begin(s, "t5c"); step_end();

        // 6: reset mid md stall (counter = 2) aborts it
        s = '0; s.md_start = 1;
        step_begin(s, "t6s"); step_end();
        s = '0; s.md_use = 1;
        step_begin(s, "t6c4"); step_end();
        step_begin(s, "t6c3"); step_end();
        step_begin(s, "t6c2"); expect_now("t6c2", 4'b0001, 2'b00, 1'b1);
        rst = 1'b1;
        m_rem = 0;
        m_bub = 1'b0;
        #1;
        expect_now("t6rst", 4'b0011, 2'b00, 1'b0);
        step_end();
        rst = 1'b0;
        step_begin(s, "t6post"); expect_now("t6post", 4'b1100, 2'b00, 1'b0); step_end();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            s = '0;
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.rw       = 5'($urandom_range(0, 3));
            s.use_rs   = ($urandom_range(0, 99) < 60);
            s.use_rt   = ($urandom_range(0, 99) < 50);
            s.md_use   = ($urandom_range(0, 99) < 40);
            s.jump     = ($urandom_range(0, 99) < 15);
            s.regwr    = ($urandom_range(0, 99) < 70);
            s.memrd    = ($urandom_range(0, 99) < 40);
            s.md_start = ($urandom_range(0, 99) < 10);
            s.br       = ($urandom_range(0, 99) < 10);
            step_begin(s, "rand");
            step_end();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
